// File: rtl/frame_scanout.sv
// Frame buffer scan-out: reads 16-pixel CD SRAM words and serialises them into a
// one-pixel-per-cycle valid/ready stream, prefetching the next word while one drains.
module frame_scanout #(
  parameter int H_PIX  = 1280,
  parameter int V_PIX  = 720,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [383:0]      sram_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [23:0]       pix_rgb,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy,
  output logic              done
);

  localparam int unsigned N_WORDS = (H_PIX * V_PIX) / 16;
  localparam int unsigned CNT_W   = $clog2(N_WORDS + 1);
  localparam int unsigned XW      = $clog2(H_PIX + 1);
  localparam int unsigned YW      = $clog2(V_PIX + 1);
  localparam logic [CNT_W-1:0] N_WORDS_C = CNT_W'(N_WORDS);
  localparam logic [XW-1:0]    X_LAST    = XW'(H_PIX - 1);
  localparam logic [YW-1:0]    Y_LAST    = YW'(V_PIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [383:0]       r_shift, r_next;
  logic               r_next_full;
  logic               r_rd_en, r_rd_pend;
  logic [ADDR_W-1:0]  r_addr;
  logic [CNT_W-1:0]   r_fetched;
  logic [3:0]         r_lane;
  logic               r_valid;
  logic [XW-1:0]      r_x;
  logic [YW-1:0]      r_y;

  logic w_hs, w_lane_end, w_x_last, w_y_last, w_frame_end;
  logic w_start, w_issue, w_direct, w_to_buf;

  assign w_hs        = r_valid && pix_ready;
  assign w_lane_end  = w_hs && (r_lane == 4'd15);
  assign w_x_last    = (r_x == X_LAST);
  assign w_y_last    = (r_y == Y_LAST);
  assign w_frame_end = w_hs && w_x_last && w_y_last;
  assign w_start     = (r_state == S_IDLE) && start;

  // One read outstanding at most, and only when the buffer is empty or emptying now.
  assign w_issue = ((r_state == S_FILL) || (r_state == S_RUN)) &&
                   (!r_next_full || w_lane_end) && !r_rd_en && !r_rd_pend &&
                   (r_fetched < N_WORDS_C);

  // Returning data bypasses the buffer when the shift register needs it this cycle.
  assign w_direct = r_rd_pend && (r_state == S_RUN) &&
                    ((w_lane_end && !r_next_full && !w_frame_end) || !r_valid);
  assign w_to_buf = r_rd_pend && (r_state == S_RUN) && !w_direct;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_FILL;
      S_FILL: begin
        busy = 1'b1;
        if (r_rd_pend) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_frame_end) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift     <= '0;
      r_next      <= '0;
      r_next_full <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_addr      <= '0;
      r_fetched   <= '0;
      r_lane      <= '0;
      r_valid     <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
    end else begin
      r_rd_en   <= w_start || w_issue;
      r_rd_pend <= r_rd_en;
      if (w_start) begin
        r_addr    <= '0;
        r_fetched <= CNT_W'(1);
      end else if (w_issue) begin
        r_addr    <= r_addr + 1'b1;
        r_fetched <= r_fetched + 1'b1;
      end

      if (w_to_buf) begin
        r_next      <= sram_rdata;
        r_next_full <= 1'b1;
      end else if (w_lane_end && r_next_full) begin
        r_next_full <= 1'b0;
      end

      case (r_state)
        S_IDLE: if (start) begin
          r_lane      <= '0;
          r_valid     <= 1'b0;
          r_x         <= '0;
          r_y         <= '0;
          r_next_full <= 1'b0;
        end
        S_FILL: if (r_rd_pend) begin
          r_shift <= sram_rdata;
          r_lane  <= '0;
          r_valid <= 1'b1;
        end
        S_RUN: begin
          if (w_hs) begin
            if (w_x_last) begin
              r_x <= '0;
              r_y <= w_y_last ? '0 : r_y + 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
            if (w_lane_end) begin
              r_lane <= '0;
              if (w_frame_end)      r_valid <= 1'b0;
              else if (r_next_full) r_shift <= r_next;
              else if (r_rd_pend)   r_shift <= sram_rdata;
              else                  r_valid <= 1'b0;
            end else begin
              r_lane  <= r_lane + 1'b1;
              r_shift <= {24'h000000, r_shift[383:24]};
            end
          end else if (!r_valid && r_rd_pend) begin
            r_shift <= sram_rdata;
            r_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sram_rd_en = r_rd_en;
  assign sram_addr  = r_addr;
  assign pix_valid  = r_valid;
  assign pix_rgb    = r_shift[23:0];
  assign pix_sol    = r_valid && (r_x == '0);
  assign pix_eol    = r_valid && w_x_last;
  assign pix_eof    = r_valid && w_x_last && w_y_last;

endmodule
